// File: rtl/i2c_slave.sv
// I2C responder at a fixed 7-bit address: receives written bytes, returns tx_data on reads.
// Optional I2C_SLAVE_GLITCH_FILTER_EN: 3-sample SCL/SDA deglitch (+2 clk edge latency).
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_t,
  output logic       sda_o,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_s, sda_s;
  logic       scl_lvl, sda_lvl;
  logic       scl_prev, sda_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;
  logic       scl_flt, sda_flt;

  // A new level passes once it agrees with the two previous samples.
  assign scl_lvl = (scl_hist == {2{scl_s}}) ? scl_s : scl_flt;
  assign sda_lvl = (sda_hist == {2{sda_s}}) ? sda_s : sda_flt;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_flt  <= 1'b1;
      sda_flt  <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_s};
      sda_hist <= {sda_hist[0], sda_s};
      scl_flt  <= scl_lvl;
      sda_flt  <= sda_lvl;
    end
  end
`else
  assign scl_lvl = scl_s;
  assign sda_lvl = sda_s;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_lvl;
      sda_prev <= sda_lvl;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_lvl & ~scl_prev;
  assign scl_fall  = ~scl_lvl & scl_prev;
  // Only current SCL level is required, so a coincident SCL edge still yields START.
  assign start_det = scl_lvl & sda_prev & ~sda_lvl;
  assign stop_det  = scl_lvl & ~sda_prev & sda_lvl;

  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic [6:0] tx_shreg, tx_shreg_n;
  logic [7:0] rx_data_n;
  logic       sda_t_n, rx_valid_n, busy_n, tx_req_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      shreg    <= 8'd0;
      tx_shreg <= 7'd0;
      sda_t    <= 1'b1;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      tx_shreg <= tx_shreg_n;
      sda_t    <= sda_t_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    tx_shreg_n = tx_shreg;
    sda_t_n    = sda_t;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    busy_n     = busy;
    tx_req_c   = 1'b0;

    if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = 4'd0;
      sda_t_n   = 1'b1;
    end else if (stop_det) begin
      state_n = IDLE;
      sda_t_n = 1'b1;
      busy_n  = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shreg_n   = {shreg[6:0], sda_lvl};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (shreg[7:1] == SLAVE_ADDR) begin
              sda_t_n = 1'b0;
              busy_n  = 1'b1;
              state_n = ADDR_ACK;
            end else begin
              busy_n  = 1'b0;
              state_n = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_n = 4'd0;
            if (shreg[0]) begin
              tx_req_c   = 1'b1;
              tx_shreg_n = tx_data[6:0];
              sda_t_n    = tx_data[7];
              state_n    = RD_DATA;
            end else begin
              sda_t_n = 1'b1;
              state_n = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shreg_n   = {shreg[6:0], sda_lvl};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              rx_data_n  = {shreg[6:0], sda_lvl};
              rx_valid_n = 1'b1;
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_t_n = 1'b0;
            state_n = WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_t_n   = 1'b1;
            bit_cnt_n = 4'd0;
            state_n   = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd7) begin
              sda_t_n = 1'b1;
              state_n = RD_ACK;
            end else begin
              sda_t_n    = tx_shreg[6];
              tx_shreg_n = {tx_shreg[5:0], 1'b0};
              bit_cnt_n  = bit_cnt + 4'd1;
            end
          end
        end
        RD_ACK: begin
          // bit_cnt==8 marks a master ACK already sampled on this ninth clock.
          if (scl_rise) begin
            if (sda_lvl) begin
              busy_n  = 1'b0;
              state_n = WAIT_STOP;
            end else begin
              bit_cnt_n = 4'd8;
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            tx_req_c   = 1'b1;
            tx_shreg_n = tx_data[6:0];
            sda_t_n    = tx_data[7];
            bit_cnt_n  = 4'd0;
            state_n    = RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_req = tx_req_c & ~reset;
  assign sda_o  = 1'b0;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, wired-AND SDA, rx/tx scoreboards.
module tb_i2c_slave;
  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_i = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       sda_t, sda_o;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy;
  logic [7:0] tx_data = 8'h00;

  assign sda_bus = m_sda & (sda_t | sda_o);

  i2c_slave dut (
    .clk(clk), .reset(reset), .scl_i(scl_i), .sda_i(sda_bus),
    .sda_t(sda_t), .sda_o(sda_o), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_req(tx_req), .tx_data(tx_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  logic glitch_tol = 1'b0;
  logic [7:0] rx_exp[$];
  logic [7:0] rd_exp[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_req) tx_cnt++;
    if (rx_valid && !glitch_tol) begin
      rx_cnt++;
      if (rx_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got 0x%0h with no byte outstanding", rx_data);
      end else begin
        chk("rx_data", rx_data, rx_exp.pop_front());
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b0; wait_clk(Q);
    scl_i = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_rstart();
    m_sda = 1'b1; wait_clk(Q);
    scl_i = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    scl_i = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(Q);
    scl_i = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    wait_clk(Q);
    scl_i = 1'b1; wait_clk(Q);
    scl_i = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_clk(Q);
    scl_i = 1'b1; wait_clk(Q / 2);
    b = sda_bus;  wait_clk(Q / 2);
    scl_i = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
  } wr_vec_t;

  wr_vec_t vecs[4];

  initial begin
    logic       ack;
    logic [7:0] rd;
    int rx0, tx0;

    vecs[0] = '{8'h78, 8'hA5, 8'h3C, 1'b1};
    vecs[1] = '{8'h42, 8'h00, 8'h00, 1'b0};
    vecs[2] = '{8'h78, 8'h00, 8'hFF, 1'b1};
    vecs[3] = '{8'h7A, 8'h55, 8'h55, 1'b0};

    wait_clk(4);
    chk("rst_sda_t", sda_t, 1'b1);
    chk("rst_sda_o", sda_o, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_tx_req", tx_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    wait_clk(Q);

    // Table of write transactions, including address mismatches.
    for (int v = 0; v < 4; v++) begin
      rx0 = rx_cnt; tx0 = tx_cnt;
      i2c_start();
      write_byte(vecs[v].addr, ack);
      chk("wr_addr_ack", ack, !vecs[v].exp_ack);
      chk("wr_busy", busy, vecs[v].exp_ack);
      if (vecs[v].exp_ack) begin
        rx_exp.push_back(vecs[v].d0);
        write_byte(vecs[v].d0, ack);
        chk("wr_d0_ack", ack, 1'b0);
        rx_exp.push_back(vecs[v].d1);
        write_byte(vecs[v].d1, ack);
        chk("wr_d1_ack", ack, 1'b0);
      end
      i2c_stop();
      wait_clk(Q);
      chk("wr_busy_stop", busy, 1'b0);
      chk("wr_rx_cnt", rx_cnt - rx0, vecs[v].exp_ack ? 2 : 0);
      chk("wr_tx_cnt", tx_cnt - tx0, 0);
      chk("wr_rx_pending", rx_exp.size(), 0);
    end

    // Read two bytes: ACK the first, NACK the second.
    tx0 = tx_cnt;
    tx_data = 8'h5A; rd_exp.push_back(8'h5A);
    i2c_start();
    write_byte(8'h79, ack);
    chk("rd_addr_ack", ack, 1'b0);
    read_byte(rd);
    chk("rd_byte0", rd, rd_exp.pop_front());
    tx_data = 8'hC3; rd_exp.push_back(8'hC3);
    write_bit(1'b0);
    read_byte(rd);
    chk("rd_byte1", rd, rd_exp.pop_front());
    write_bit(1'b1);
    chk("rd_nack_sda_t", sda_t, 1'b1);
    chk("rd_nack_busy", busy, 1'b0);
    i2c_stop();
    chk("rd_tx_cnt", tx_cnt - tx0, 2);

    // Write then repeated START into a read.
    rx0 = rx_cnt; tx0 = tx_cnt;
    tx_data = 8'h96; rd_exp.push_back(8'h96);
    i2c_start();
    write_byte(8'h78, ack);
    chk("sr_wr_ack", ack, 1'b0);
    rx_exp.push_back(8'h01);
    write_byte(8'h01, ack);
    chk("sr_d_ack", ack, 1'b0);
    i2c_rstart();
    write_byte(8'h79, ack);
    chk("sr_rd_ack", ack, 1'b0);
    read_byte(rd);
    chk("sr_rd_byte", rd, rd_exp.pop_front());
    write_bit(1'b1);
    i2c_stop();
    chk("sr_rx_cnt", rx_cnt - rx0, 1);
    chk("sr_tx_cnt", tx_cnt - tx0, 1);

    // Reset while the slave drives the 4th bit of a read byte.
    tx_data = 8'h00;
    i2c_start();
    write_byte(8'h79, ack);
    chk("rr_addr_ack", ack, 1'b0);
    for (int i = 0; i < 3; i++) read_bit(ack);
    chk("rr_driving", sda_t, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rr_release", sda_t, 1'b1);
    wait_clk(3);
    reset = 1'b0;
    chk("rr_busy", busy, 1'b0);
    wait_clk(Q);
    i2c_stop();
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'h78, ack);
    chk("rr_new_ack", ack, 1'b0);
    rx_exp.push_back(8'h5C);
    write_byte(8'h5C, ack);
    chk("rr_new_d_ack", ack, 1'b0);
    i2c_stop();
    chk("rr_rx_cnt", rx_cnt - rx0, 1);

    // One-clock SCL glitch in the low phase of a data byte.
    i2c_start();
    write_byte(8'h78, ack);
    chk("gl_addr_ack", ack, 1'b0);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    rx_exp.push_back(8'h96);
`else
    glitch_tol = 1'b1;
`endif
    for (int i = 7; i >= 4; i--) write_bit(rd_bit(8'h96, i));
    scl_i = 1'b1; wait_clk(1);
    scl_i = 1'b0; wait_clk(Q);
    for (int i = 3; i >= 0; i--) write_bit(rd_bit(8'h96, i));
    read_bit(ack);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    chk("gl_d_ack", ack, 1'b0);
    i2c_stop();
`else
    reset = 1'b1; wait_clk(3);
    reset = 1'b0; wait_clk(Q);
    i2c_stop();
    glitch_tol = 1'b0;
    rx_exp.delete();
`endif
    wait_clk(Q);
    chk("final_rx_pending", rx_exp.size(), 0);
    chk("final_sda_t", sda_t, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic rd_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
